pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: resets the PLL, waits for a qualified lock, then releases
// downstream channel resets one after another and watches for lock loss.
module pll_reset_sequencer #(
    parameter int NUM_CH          = 2,
    parameter int PLL_RST_CYC     = 16,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int STAGGER_CYC     = 8,
    parameter int TIMEOUT_CYC     = 65536,
    parameter int CNT_W           = 8
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              relock_req,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic [CNT_W-1:0]  lock_loss_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);

    localparam int REL_SPAN = (NUM_CH - 1) * STAGGER_CYC;
    localparam int MAX_A    = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
    localparam int MAX_B    = (TIMEOUT_CYC > REL_SPAN) ? TIMEOUT_CYC : REL_SPAN;
    localparam int MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] REL_LAST    = CW'(REL_SPAN);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sync1_q, locked_s_q;
    logic              pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0] rst_out_q, rst_out_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  llc_q, llc_d;
    logic [CNT_W-1:0]  toc_q, toc_d;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // Next-state, cycle counter, event counters and registered output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        rst_out_d = '1;
        llc_d     = llc_q;
        toc_d     = toc_q;
        case (state_q)
            S_PLL_RST: begin
                if (relock_req) begin
                    cnt_d = '0;
                end else if (cnt_q == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    state_d = S_PLL_RST;
                end
            end
            S_WAIT_LOCK: begin
                if (relock_req) begin
                    state_d = S_PLL_RST;
                end else if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RST;
                    toc_d   = sat_inc(toc_q);
                end else begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_STABLE: begin
                if (relock_req) begin
                    state_d = S_PLL_RST;
                end else if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_STABLE;
                end
            end
            S_RELEASE: begin
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    llc_d   = sat_inc(llc_q);
                end else if (relock_req) begin
                    state_d = S_PLL_RST;
                end else begin
                    // Channel k drops once the release count reaches k*STAGGER_CYC
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (int'(cnt_q) >= k * STAGGER_CYC) begin
                            rst_out_d[k] = 1'b0;
                        end else begin
                            rst_out_d[k] = rst_out_q[k];
                        end
                    end
                    if (cnt_q == REL_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s_q) begin
                    state_d = S_PLL_RST;
                    llc_d   = sat_inc(llc_q);
                end else if (relock_req) begin
                    state_d = S_PLL_RST;
                end else begin
                    rst_out_d = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end
        pll_rst_d = (state_d == S_PLL_RST);
        ready_d   = (state_d == S_RUN);
    end

    // State, counter and output registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            llc_q     <= '0;
            toc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            llc_q     <= llc_d;
            toc_q     <= toc_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign rst_out       = rst_out_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = llc_q;
    assign timeout_cnt   = toc_q;

endmodule
